// File: rtl/bus_arbiter2_pkg.sv
// Shared definitions for the two-requester operand-bus arbiter:
// FSM state encodings, default widths and the hold-counter width.
package bus_arbiter2_pkg;

  localparam int DEFAULT_N        = 16;
  localparam int DEFAULT_MAX_HOLD = 8;
  localparam int HOLD_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  // Saturating increment for the hold counter; it must never wrap.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    if (v == {HOLD_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/bus_arbiter2_if.sv
// Operand-bus bundle between the two requesters / consumer and the arbiter.
// master: requesters and consumer side; slave: the arbiter itself.
interface bus_arbiter2_if #(
  parameter int N = 16
);
  logic         req0;
  logic         last0;
  logic [N-1:0] data_in0;
  logic         req1;
  logic         last1;
  logic [N-1:0] data_in1;
  logic         ready;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [N-1:0] data_out;
  logic         out_valid;
  logic         beat;

  modport master (
    output req0, last0, data_in0, req1, last1, data_in1, ready,
    input  gnt0, gnt1, sel, data_out, out_valid, beat
  );

  modport slave (
    input  req0, last0, data_in0, req1, last1, data_in1, ready,
    output gnt0, gnt1, sel, data_out, out_valid, beat
  );
endinterface

// File: rtl/bus_arbiter2_mux2.sv
// Generic 2:1 word multiplexer; sel=1 picks input b.
module bus_arbiter2_mux2 #(
  parameter int W = 16
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter for the shared operand bus.
// Grants one requester at a time for a multi-beat transaction, forces a
// handover after MAX_HOLD beats when the other side waits, and registers
// the selected word toward the consumer.
module bus_arbiter2
  import bus_arbiter2_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input logic            clk,
  input logic            rst_n,
  bus_arbiter2_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_e              state_r;
  logic                ptr_r;       // 0 favours requester 0 on contention
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                gnt0_r;
  logic                gnt1_r;
  logic [N-1:0]        data_out_r;
  logic                out_valid_r;

  logic                own_s;
  logic                req_x_s;
  logic                last_x_s;
  logic                req_other_s;
  logic                beat_s;
  logic                preempt_s;
  logic                release_s;
  logic [N-1:0]        mux_y_s;

  // View the current owner's handshake as "x" and the competitor as "other".
  always_comb begin
    own_s       = 1'b0;
    req_x_s     = 1'b0;
    last_x_s    = 1'b0;
    req_other_s = 1'b0;
    case (state_r)
      ST_OWN0: begin
        own_s       = 1'b1;
        req_x_s     = bus.req0;
        last_x_s    = bus.last0;
        req_other_s = bus.req1;
      end
      ST_OWN1: begin
        own_s       = 1'b1;
        req_x_s     = bus.req1;
        last_x_s    = bus.last1;
        req_other_s = bus.req0;
      end
      default: begin
        own_s       = 1'b0;
        req_x_s     = 1'b0;
        last_x_s    = 1'b0;
        req_other_s = 1'b0;
      end
    endcase
  end

  // Beat and release decode; last and preemption together give one release.
  always_comb begin
    beat_s    = own_s & req_x_s & bus.ready;
    preempt_s = beat_s & req_other_s & (hold_cnt_r == HOLD_LAST);
    release_s = own_s & (~req_x_s | (beat_s & last_x_s) | preempt_s);
  end

  // Ownership FSM with registered grants, round-robin pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gnt0_r     <= 1'b0;
      gnt1_r     <= 1'b0;
      ptr_r      <= 1'b0;
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          hold_cnt_r <= {HOLD_W{1'b0}};
          if (bus.req0 && bus.req1) begin
            state_r <= ptr_r ? ST_OWN1 : ST_OWN0;
            gnt0_r  <= ~ptr_r;
            gnt1_r  <= ptr_r;
          end else if (bus.req0) begin
            state_r <= ST_OWN0;
            gnt0_r  <= 1'b1;
            gnt1_r  <= 1'b0;
          end else if (bus.req1) begin
            state_r <= ST_OWN1;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
          end
        end
        ST_OWN0: begin
          if (release_s) begin
            state_r    <= bus.req1 ? ST_OWN1 : ST_IDLE;
            gnt0_r     <= 1'b0;
            gnt1_r     <= bus.req1;
            ptr_r      <= 1'b1;
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (!bus.req1) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (beat_s) begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        ST_OWN1: begin
          if (release_s) begin
            state_r    <= bus.req0 ? ST_OWN0 : ST_IDLE;
            gnt0_r     <= bus.req0;
            gnt1_r     <= 1'b0;
            ptr_r      <= 1'b0;
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (!bus.req0) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (beat_s) begin
            hold_cnt_r <= sat_inc(hold_cnt_r);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          gnt0_r     <= 1'b0;
          gnt1_r     <= 1'b0;
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

  bus_arbiter2_mux2 #(.W(N)) u_mux (
    .sel (gnt1_r),
    .a   (bus.data_in0),
    .b   (bus.data_in1),
    .y   (mux_y_s)
  );

  // Output word register: capture on a beat, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r  <= {N{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= beat_s;
      if (beat_s) begin
        data_out_r <= mux_y_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.sel       = gnt1_r;
  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.beat      = beat_s;

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed self-checking bench for bus_arbiter2 (MAX_HOLD=4).
// Expected words are queued when a beat is expected and popped when the
// registered output reports out_valid.
module tb_bus_arbiter2;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   step_no  = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_word;
  logic [15:0] exp_w;

  bus_arbiter2_if #(.N(16)) bus ();

  bus_arbiter2 #(.N(16), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic l0, input logic [15:0] d0,
                       input logic r1, input logic l1, input logic [15:0] d1,
                       input logic rdy);
    bus.req0 = r0; bus.last0 = l0; bus.data_in0 = d0;
    bus.req1 = r1; bus.last1 = l1; bus.data_in1 = d1;
    bus.ready = rdy;
  endtask

  // One clock cycle: called just after a rising edge with inputs applied.
  task automatic step(input logic eg0, input logic eg1, input logic eb, input logic [15:0] ew);
    step_no++;
    @(negedge clk);
    check("gnt0", {15'd0, bus.gnt0}, {15'd0, eg0});
    check("gnt1", {15'd0, bus.gnt1}, {15'd0, eg1});
    check("sel",  {15'd0, bus.sel},  {15'd0, eg1});
    check("beat", {15'd0, bus.beat}, {15'd0, eb});
    if (eb) sb_q.push_back(ew);
    @(posedge clk);
    #1;
    check("out_valid", {15'd0, bus.out_valid}, {15'd0, eb});
    if (bus.out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 16'd1, 16'd0);
      end else begin
        exp_w = sb_q.pop_front();
        check("data_out", bus.data_out, exp_w);
        last_word = exp_w;
      end
    end else begin
      check("data_hold", bus.data_out, last_word);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    last_word = 16'h0000;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt0", {15'd0, bus.gnt0}, 16'd0);
    check("rst_gnt1", {15'd0, bus.gnt1}, 16'd0);
    check("rst_sel", {15'd0, bus.sel}, 16'd0);
    check("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    check("rst_data", bus.data_out, 16'h0000);
    rst_n = 1'b1;

    // Contention from IDLE after reset: requester 0 first, then 1 with no bubble.
    drive(1'b1, 1'b1, 16'hA001, 1'b1, 1'b1, 16'hB001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hA001);
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'hB001, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'hB001);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Single requester, three beats, back to IDLE.
    drive(1'b1, 1'b0, 16'h0011, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0011);
    drive(1'b1, 1'b0, 16'h0022, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h0022);
    drive(1'b1, 1'b1, 16'h0033, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'h0033);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Contention again: pointer now favours requester 1.
    drive(1'b1, 1'b1, 16'hA002, 1'b1, 1'b1, 16'hB002, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'hB002);
    drive(1'b1, 1'b1, 16'hA002, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'hA002);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Forced preemption: 10-beat transaction from 0 while 1 waits.
    drive(1'b1, 1'b0, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 16'h0100 + 16'(k), 1'b1, 1'b1, 16'hB003, 1'b1);
      step(1'b1, 1'b0, 1'b1, 16'h0100 + 16'(k));
    end
    drive(1'b1, 1'b0, 16'h0105, 1'b1, 1'b1, 16'hB003, 1'b1);
    step(1'b0, 1'b1, 1'b1, 16'hB003);
    for (int k = 5; k <= 10; k++) begin
      drive(1'b1, (k == 10), 16'h0100 + 16'(k), 1'b0, 1'b0, 16'h0000, 1'b1);
      step(1'b1, 1'b0, 1'b1, 16'h0100 + 16'(k));
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Backpressure: ready 1,0,0,1 gives two beats.
    drive(1'b1, 1'b0, 16'hC001, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hC001);
    drive(1'b1, 1'b1, 16'hC002, 1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 16'h0000);
    drive(1'b1, 1'b1, 16'hC002, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b1, 1'b0, 1'b1, 16'hC002);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Withdrawal: requester 1 drops without last while 0 waits.
    drive(1'b1, 1'b1, 16'hA0D1, 1'b1, 1'b0, 16'hD001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'hD001);
    drive(1'b1, 1'b1, 16'hA0D1, 1'b0, 1'b0, 16'hD002, 1'b1);
    step(1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hA0D1);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    // Reset in the middle of an OWN1 transaction.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'hE001, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'hE001);
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt0", {15'd0, bus.gnt0}, 16'd0);
    check("mid_rst_gnt1", {15'd0, bus.gnt1}, 16'd0);
    check("mid_rst_sel", {15'd0, bus.sel}, 16'd0);
    check("mid_rst_valid", {15'd0, bus.out_valid}, 16'd0);
    check("mid_rst_data", bus.data_out, 16'h0000);
    last_word = 16'h0000;
    drive(1'b1, 1'b1, 16'hF001, 1'b0, 1'b0, 16'h0000, 1'b1);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'hF001);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'h0000);

    check("sb_leftover", 16'(sb_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter2.md
Name: bus_arbiter2

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16-bit operand bus of the pocket-calculator processor.
- Owns the select of the bus 2:1 multiplexer. It grants one requester at a time, holds the grant for a multi-beat transaction, and forces a handover after MAX_HOLD beats when the other side is waiting.
- Registers the selected word toward the ALU/register-file consumer.

Parameters:
- N, 16, data width of each requester's bus word.
- MAX_HOLD, 8, maximum beats per grant while the other requester is waiting (2..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 wants the bus; held high for the whole transaction.
- last0  input  1  current beat of requester 0 is its final beat.
- data_in0  input  N  requester 0 word.
- req1  input  1  requester 1 wants the bus.
- last1  input  1  requester 1 final-beat flag.
- data_in1  input  N  requester 1 word.
- ready  input  1  consumer accepts a beat this cycle.
- gnt0  output  1  requester 0 owns the bus (registered).
- gnt1  output  1  requester 1 owns the bus (registered).
- sel  output  1  mux select, 1 = requester 1; equals gnt1.
- data_out  output  N  registered bus word.
- out_valid  output  1  data_out holds a new beat this cycle.
- beat  output  1  combinational: a transfer occurs this cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; gnt0=gnt1=sel=0; data_out=0; out_valid=0.
  - Priority pointer favours requester 0; hold counter=0.
- States: IDLE, OWN0, OWN1. gnt0=(state==OWN0), gnt1=(state==OWN1). The two grants are never high together.
- IDLE:
  - req0&req1 -> OWN of the pointer-favoured requester.
  - A single request -> OWN of that requester.
  - No request -> stay in IDLE.
  - A grant is visible the cycle after the request is seen (1-cycle grant latency).
- OWNx, beat definition: beat = gnt_x & req_x & ready.
  - On a beat: data_out <= data_in_x; out_valid <= 1 next cycle (1-cycle data latency). Otherwise out_valid <= 0.
- OWNx, release conditions:
  - (a) beat & last_x.
  - (b) req_x low: no beat; release immediately.
  - (c) beat & req_other & hold_cnt==MAX_HOLD-1: forced preemption.
- On release:
  - Next state is OWN_other if req_other is high, else IDLE.
  - Pointer <= other; hold_cnt <= 0.
- Hold counter:
  - Increments on each beat while req_other is high.
  - Saturates, never wraps.
  - Clears on release, and when req_other is low.
  - With no competitor, transactions of any length are never preempted.
- Simultaneous events:
  - last_x and the forced-preemption condition in the same beat: a single release; the pointer still moves to other.
  - req_other rising on the same cycle as release: handover goes directly to OWN_other, with no IDLE bubble.
- ready low: no beat. State, counter and data_out hold. out_valid=0.
- Forced preemption is not an error. The requester keeps req high and is re-granted later to continue the transaction.
- Reset mid-transaction: outputs clear immediately (asynchronously). No partial beat is emitted after reset deasserts.

Decomposition:
- Shared package/include holds:
  - State encodings: IDLE=2'd0, OWN0=2'd1, OWN1=2'd2.
  - Default widths.
- The datapath select is natural as an instance of the team's existing 2:1 multiplexer, driven by sel, feeding the data_out register.
- The rest (FSM, pointer, hold counter) stays in bus_arbiter2.

Test Plan:
- Reset: rst_n=0 asserted mid-transaction in OWN1 -> gnt0=gnt1=0, out_valid=0, data_out=0 the same cycle; after release with only req0=1, gnt0=1 one cycle later.
- Single requester: req0=1 for 3 beats, ready=1, data 0x0011/0x0022/0x0033, last0 on the third -> data_out shows those values on cycles N+1..N+3 with out_valid=1; back to IDLE next cycle.
- Contention from IDLE: req0=req1=1 after reset -> gnt0 first. After req0's 1-beat transaction, gnt1 follows on the next cycle with no IDLE cycle. A new req0&req1 from IDLE then grants req1... only if the pointer favours it; the required result is that the pointer alternates grants.
- Forced preemption: MAX_HOLD=4, requester 0 issues a 10-beat transaction while req1=1 -> exactly 4 beats from 0, then gnt1. Requester 1 sends 1 beat, then requester 0 resumes at beat 5.
- Backpressure: ready toggling 1,0,0,1 during OWN0 -> only 2 beats counted, out_valid is low on the stalled cycles, and data_out holds its last value.
- Withdrawal: req1 drops in OWN1 with no last1 while req0=1 -> no beat that cycle; gnt0 asserts the next cycle.
